inactivity_scheduler: RTL and testbench

Sequences the shared clock-division and inactivity-timeout resource: a programmable prescaler produces a one-cycle `tick` strobe from `clock`, and an FSM counts ticks since the last user activity, raising `timeout` when a programmable limit expires. It sits between the user-input front end (source of `activity` pulses) and the session/lock logic that consumes `timeout` and `tick`.

---
 rtl/inactivity_scheduler.sv | 167 ++++++++++++++++
 tb/tb_inactivity_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inactivity_scheduler.sv
// inactivity_scheduler
// Programmable prescaler producing a one-cycle tick strobe, plus an
// inactivity FSM that counts ticks since the last activity pulse and
// raises timeout when the programmed limit expires.
//
// Optional feature: define INACT_WARN_EN to add the registered `warn`
// output, high while ARMED with exactly one tick remaining.
//
// Control priority per edge: enable=0 > clear > activity > prescaler wrap.
// All outputs come straight from flops; state encoding is exposed on
// `state` for observation (IDLE=00, ARMED=01, EXPIRED=10, 11 -> IDLE).
module inactivity_scheduler #(
    parameter int CNT_W = 8,
    parameter int TMO_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             activity,
    input  logic [CNT_W-1:0] div_sel,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             tick,
    output logic             timeout,
    output logic [1:0]       state,
    output logic [TMO_W-1:0] remaining
`ifdef INACT_WARN_EN
    ,
    output logic             warn
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_EXPIRED = 2'b10
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             timeout_q;
    logic [TMO_W-1:0] rem_q;
`ifdef INACT_WARN_EN
    logic             warn_q;
`endif

    logic [TMO_W-1:0] load_val;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;

    // Reload value (a zero limit behaves as one tick) and prescaler wrap
    // detect; >= lets a lowered div_sel wrap on the very next edge.
    always_comb begin
        load_val = (tmo_limit == '0) ? TMO_W'(1) : tmo_limit;
        wrap     = (cnt_q >= div_sel);
        cnt_inc  = cnt_q + 1'b1;
    end

    // Scheduler FSM with prescaler and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            timeout_q <= 1'b0;
            rem_q     <= '0;
`ifdef INACT_WARN_EN
            warn_q    <= 1'b0;
`endif
        end else if (!enable || clear) begin
            // Both force IDLE with every output at its reset value.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            timeout_q <= 1'b0;
            rem_q     <= '0;
`ifdef INACT_WARN_EN
            warn_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (activity) begin
                        // Restart the schedule; a coincident wrap is dropped.
                        cnt_q  <= '0;
                        tick_q <= 1'b0;
                        rem_q  <= load_val;
`ifdef INACT_WARN_EN
                        warn_q <= (load_val == TMO_W'(1));
`endif
                    end else if (wrap) begin
                        cnt_q  <= '0;
                        tick_q <= 1'b1;
                        if (rem_q <= TMO_W'(1)) begin
                            state_q   <= S_EXPIRED;
                            timeout_q <= 1'b1;
                            rem_q     <= '0;
`ifdef INACT_WARN_EN
                            warn_q    <= 1'b0;
`endif
                        end else begin
                            rem_q <= rem_q - 1'b1;
`ifdef INACT_WARN_EN
                            warn_q <= (rem_q == TMO_W'(2));
`endif
                        end
                    end else begin
                        cnt_q  <= cnt_inc;
                        tick_q <= 1'b0;
`ifdef INACT_WARN_EN
                        warn_q <= (rem_q == TMO_W'(1));
`endif
                    end
                end

                S_EXPIRED: begin
                    if (activity) begin
                        state_q   <= S_ARMED;
                        cnt_q     <= '0;
                        tick_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        rem_q     <= load_val;
`ifdef INACT_WARN_EN
                        warn_q    <= (load_val == TMO_W'(1));
`endif
                    end else begin
                        // Prescaler keeps running so tick stays periodic.
                        timeout_q <= 1'b1;
                        rem_q     <= '0;
                        if (wrap) begin
                            cnt_q  <= '0;
                            tick_q <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_inc;
                            tick_q <= 1'b0;
                        end
`ifdef INACT_WARN_EN
                        warn_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    // IDLE (and the unused 11 code): arm immediately.
                    state_q   <= S_ARMED;
                    cnt_q     <= '0;
                    tick_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    rem_q     <= load_val;
`ifdef INACT_WARN_EN
                    warn_q    <= (load_val == TMO_W'(1));
`endif
                end
            endcase
        end
    end

    assign tick      = tick_q;
    assign timeout   = timeout_q;
    assign state     = state_q;
    assign remaining = rem_q;
`ifdef INACT_WARN_EN
    assign warn      = warn_q;
`endif

endmodule

// File: tb/tb_inactivity_scheduler.sv
// Bench for inactivity_scheduler: scenario tasks push expected
// {state, tick, timeout, remaining} words into exp_q as stimulus is
// driven and pop/compare them one cycle-result at a time.
module tb_inactivity_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       activity = 1'b0;
  logic [7:0] div_sel = 8'd0;
  logic [3:0] tmo_limit = 4'd0;
  logic       tick;
  logic       timeout;
  logic [1:0] state;
  logic [3:0] remaining;
`ifdef INACT_WARN_EN
  logic       warn;
`endif

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  inactivity_scheduler #(.CNT_W(8), .TMO_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .activity  (activity),
    .div_sel   (div_sel),
    .tmo_limit (tmo_limit),
    .tick      (tick),
    .timeout   (timeout),
    .state     (state),
    .remaining (remaining)
`ifdef INACT_WARN_EN
    ,
    .warn      (warn)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver: advance one rising edge, land 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    clear = 1'b0;
    activity = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    #1 reset = 1'b0;
    #1;
    got = {state, tick, timeout, remaining};
    n_cmp++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL reset_initial got=%h exp=%h", got, 8'h00);
    end
    reset = 1'b1;
    go_idle();
    div_sel = 8'd3;
    tmo_limit = 4'd4;
    enable = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) step();
    got = {state, tick, timeout, remaining};
    n_cmp++;
    if (got !== {2'b01, 1'b0, 1'b0, 4'd3}) begin
      n_err++;
      $display("FAIL reset_precond got=%h exp=%h", got, {2'b01, 1'b0, 1'b0, 4'd3});
    end
    #2 reset = 1'b0;
    #1;
    got = {state, tick, timeout, remaining};
    n_cmp++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", got, 8'h00);
    end
    #2 reset = 1'b1;
    go_idle();
  endtask

  // Arms with (div, lim), optional activity pulse sampled at edge act_edge
  // (0 = none), checks every edge up to n_edges against the schedule.
  task automatic test_schedule(input string name, input int div, input int lim,
                               input int act_edge, input int n_edges);
    int n, p, j, t;
    logic tk;
    logic [7:0] got, exp;
    go_idle();
    div_sel = 8'(div);
    tmo_limit = 4'(lim);
    n = (lim == 0) ? 1 : lim;
    p = div + 1;
    enable = 1'b1;
    exp_q.push_back({2'b01, 1'b0, 1'b0, 4'(n)});
    step();
    got = {state, tick, timeout, remaining};
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s arm got=%h exp=%h", name, got, exp);
    end
    for (int k = 1; k <= n_edges; k++) begin
      j = (act_edge > 0 && k >= act_edge) ? k - act_edge : k;
      tk = (j > 0) && (j % p == 0);
      t = j / p;
      if (t >= n) exp_q.push_back({2'b10, tk, 1'b1, 4'd0});
      else exp_q.push_back({2'b01, tk, 1'b0, 4'(n - t)});
      activity = (k == act_edge);
      step();
      activity = 1'b0;
      got = {state, tick, timeout, remaining};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s edge=%0d got=%h exp=%h", name, k, got, exp);
      end
    end
  endtask

  task automatic test_clear_expired();
    logic [7:0] got, exp;
    go_idle();
    div_sel = 8'd3;
    tmo_limit = 4'd4;
    enable = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) step();
    exp_q.push_back({2'b10, 1'b1, 1'b1, 4'd0});
    exp_q.push_back({2'b00, 1'b0, 1'b0, 4'd0});
    exp_q.push_back({2'b01, 1'b0, 1'b0, 4'd4});
    for (int k = 0; k < 3; k++) begin
      if (k == 1) clear = 1'b1;
      if (k > 0) step();
      clear = 1'b0;
      got = {state, tick, timeout, remaining};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL clear_expired step=%0d got=%h exp=%h", k, got, exp);
      end
    end
    for (int k = 1; k <= 4; k++) step();
    exp = {2'b01, 1'b1, 1'b0, 4'd3};
    got = {state, tick, timeout, remaining};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL clear_rearm_tick got=%h exp=%h", got, exp);
    end
  endtask

  // div_sel lowered 7->2 when count=5 wraps on the next edge; tmo_limit
  // change mid-count does not disturb remaining.
  task automatic test_div_change();
    logic [7:0] got, exp;
    logic tk;
    go_idle();
    div_sel = 8'd7;
    tmo_limit = 4'd4;
    enable = 1'b1;
    step();
    for (int k = 1; k <= 9; k++) begin
      tk = (k == 6) || (k == 9);
      exp_q.push_back({2'b01, tk, 1'b0, (k < 6) ? 4'd4 : (k < 9) ? 4'd3 : 4'd2});
      if (k == 6) begin
        div_sel = 8'd2;
        tmo_limit = 4'd9;
      end
      step();
      got = {state, tick, timeout, remaining};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL div_change edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_enable_low();
    logic [7:0] got;
    go_idle();
    div_sel = 8'd1;
    tmo_limit = 4'd5;
    enable = 1'b1;
    step();
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      got = {state, tick, timeout, remaining};
      n_cmp++;
      if (got !== 8'h00) begin
        n_err++;
        $display("FAIL enable_low step=%0d got=%h exp=%h", k, got, 8'h00);
      end
    end
  endtask

`ifdef INACT_WARN_EN
  task automatic test_warn();
    logic [7:0] got, exp;
    go_idle();
    div_sel = 8'd1;
    tmo_limit = 4'd3;
    enable = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({7'd0, (k == 4) || (k == 5)});
      step();
      got = {7'd0, warn};
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL warn edge=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_schedule("no_activity", 3, 4, 0, 20);
    test_schedule("activity_e10", 3, 4, 10, 28);
    test_schedule("activity_on_wrap", 3, 4, 4, 12);
    test_schedule("expired_activity", 3, 4, 18, 24);
    test_schedule("div0_lim0", 0, 0, 0, 4);
    test_clear_expired();
    test_div_change();
    test_enable_low();
`ifdef INACT_WARN_EN
    test_warn();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
